// File: rtl/synth_reg_write_ctrl_pkg.sv
// Shared types and helpers for the synth register-write front end.
//   reg_write_t  : one register write (16-bit register number + 8-bit value)
//   RegFrameBits : length of one SPI write frame in bits
//   sat_count5() : FIFO occupancy clipped to the 5-bit field of the status byte
package synth_reg_write_ctrl_pkg;

  localparam int unsigned RegFrameBits = 24;

  typedef struct packed {
    logic [15:0] number;
    logic [7:0]  value;
  } reg_write_t;

  function automatic logic [4:0] sat_count5(input int unsigned n);
    return (n > 32'd31) ? 5'd31 : n[4:0];
  endfunction

endpackage

// File: rtl/synth_reg_write_ctrl_reg_write_fifo.sv
// reg_write_fifo: synchronous FIFO of reg_write_t entries.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset (FIFO empties)
//   push_i, wdata_i      write request and data; ignored when full unless popping too
//   pop_i, rdata_o       read request; rdata_o shows the head entry combinationally
//   full_o, empty_o      occupancy flags
//   count_o              number of stored entries (0..Depth)
// A push into a full FIFO is accepted when a pop happens in the same cycle: the head is read
// out before the freed slot is overwritten.
module reg_write_fifo
  import synth_reg_write_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  reg_write_t      wdata_i,
  input  logic            pop_i,
  output reg_write_t      rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  reg_write_t mem_q [Depth];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PtrW:0] wptr_q, wptr_d;
  logic [PtrW:0] rptr_q, rptr_d;
  logic          push_ok, pop_ok;

  always_comb begin
    count_o = wptr_q - rptr_q;
    full_o  = (count_o == CntW'(Depth));
    empty_o = (count_o == '0);
    rdata_o = mem_q[rptr_q[PtrW-1:0]];
    pop_ok  = pop_i & ~empty_o;
    push_ok = push_i & (~full_o | pop_ok);
    wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop_ok  ? rptr_q + 1'b1 : rptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/synth_reg_write_ctrl.sv
// synth_reg_write_ctrl: SPI-slave configuration front end for synth.
// Receives 24-bit SPI frames {number[15:8], number[7:0], value}, buffers them in a FIFO and
// issues them as one-cycle register-write strobes on the synth register-write bus.
// Ports:
//   i_Clock, i_Reset_n          system clock, asynchronous active-low reset
//   i_SpiSclk/i_SpiCs_n/i_SpiMosi  asynchronous SPI inputs (mode 0, MSB first)
//   o_SpiMiso                   status byte {overflow, 2'b0, fifo count} during bits 0-7
//   i_SampleReady               synth sample pulse (only used with sample-aligned writes)
//   o_RegisterWrite*            registered write strobe, register number and value
//   o_Overflow                  sticky: a complete frame was dropped on a full FIFO
//   o_Busy                      FIFO non-empty or a frame partly received
// Build option: define SAMPLE_ALIGNED_WRITES_EN to hold writes until i_SampleReady and then
// drain the whole FIFO back-to-back, so one sample never sees a half-applied burst.
module synth_reg_write_ctrl
  import synth_reg_write_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_SpiSclk,
  input  logic        i_SpiCs_n,
  input  logic        i_SpiMosi,
  output logic        o_SpiMiso,
  input  logic        i_SampleReady,
  output logic        o_RegisterWriteEnable,
  output logic [15:0] o_RegisterWriteNumber,
  output logic [7:0]  o_RegisterWriteValue,
  output logic        o_Overflow,
  output logic        o_Busy
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  // Input synchronisers; the last stage is the usable synced value.
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_s, cs_n_s, mosi_s;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  always_comb begin
    sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    cs_n_s    = cs_sync_q[SYNC_STAGES-1];
    mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_prev_q;
    sclk_fall = ~sclk_s & sclk_prev_q;
    cs_fall   = ~cs_n_s & cs_prev_q;
    cs_rise   = cs_n_s & ~cs_prev_q;
  end

  // Frame receiver.
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic [RegFrameBits-1:0] shift_q, shift_d;
  logic                    frame_done;
  logic                    latch_req_q, latch_req_d;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_done  = 1'b0;
    latch_req_d = 1'b0;
    if (cs_fall) begin
      bit_cnt_d   = '0;
      latch_req_d = 1'b1;
    end else if (cs_rise) begin
      // Partial frame is simply forgotten.
      bit_cnt_d = '0;
    end else if (!cs_n_s && sclk_rise) begin
      shift_d = {shift_q[RegFrameBits-2:0], mosi_s};
      if (bit_cnt_q == 5'(RegFrameBits - 1)) begin
        bit_cnt_d   = '0;
        frame_done  = 1'b1;
        latch_req_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end
  end

  // FIFO and write scheduling.
  reg_write_t      push_data, fifo_rdata;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            pop;

  assign push_data = reg_write_t'(shift_d);

  reg_write_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_Clock),
    .rst_ni  (i_Reset_n),
    .push_i  (frame_done),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef SAMPLE_ALIGNED_WRITES_EN
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StArmed = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StArmed;
      end
      StArmed: begin
        if (i_SampleReady) begin
          pop     = !fifo_empty;
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Keeps draining entries that arrive mid-burst; sample pulses here are ignored.
        if (fifo_empty) state_d = StIdle;
        else            pop     = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state_q <= StIdle;
    else            state_q <= state_d;
  end
`else
  logic unused_sample_ready;
  assign unused_sample_ready = i_SampleReady;
  assign pop = !fifo_empty;
`endif

  // Status byte and MISO.
  logic       overflow_q, overflow_d;
  logic [7:0] status_q, status_d;
  logic       miso_q, miso_d;
  logic       we_q, we_d;
  reg_write_t wr_q, wr_d;

  always_comb begin
    overflow_d = overflow_q | (frame_done & fifo_full & ~pop);
    status_d   = status_q;
    // Latched a cycle after frame start so a drop or push in that cycle is already visible.
    if (latch_req_q) begin
      status_d = {overflow_q, 2'b00, sat_count5(32'(fifo_count))};
    end else if (!cs_n_s && sclk_fall && bit_cnt_q != 5'd0 && bit_cnt_q < 5'd8) begin
      status_d = {status_q[6:0], 1'b0};
    end
    miso_d = (!cs_n_s && bit_cnt_q < 5'd8) ? status_d[7] : 1'b0;
    we_d   = pop;
    wr_d   = pop ? fifo_rdata : '0;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      latch_req_q <= 1'b0;
      status_q    <= '0;
      miso_q      <= 1'b0;
      overflow_q  <= 1'b0;
      we_q        <= 1'b0;
      wr_q        <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_SpiSclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_SpiCs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_SpiMosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_n_s;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      latch_req_q <= latch_req_d;
      status_q    <= status_d;
      miso_q      <= miso_d;
      overflow_q  <= overflow_d;
      we_q        <= we_d;
      wr_q        <= wr_d;
    end
  end

  assign o_SpiMiso             = miso_q;
  assign o_RegisterWriteEnable = we_q;
  assign o_RegisterWriteNumber = wr_q.number;
  assign o_RegisterWriteValue  = wr_q.value;
  assign o_Overflow            = overflow_q;
  assign o_Busy                = !fifo_empty || (bit_cnt_q != 5'd0);

endmodule

// File: tb/tb_synth_reg_write_ctrl.sv
// Self-checking bench for synth_reg_write_ctrl. The reference model is a queue of expected
// writes in order; every strobe on the write bus is compared against its head.
module tb_synth_reg_write_ctrl;

  localparam int unsigned Depth = 8;
  localparam int unsigned Sync  = 2;
  localparam int unsigned Half  = 8;  // system clocks per SCLK half period

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        sample_ready = 1'b0;
  logic        miso, we, ovf, busy;
  logic [15:0] num;
  logic [7:0]  val;

  always #5 clk = ~clk;

  synth_reg_write_ctrl #(
    .FIFO_DEPTH  (Depth),
    .SYNC_STAGES (Sync)
  ) dut (
    .i_Clock               (clk),
    .i_Reset_n             (rst_n),
    .i_SpiSclk             (sclk),
    .i_SpiCs_n             (cs_n),
    .i_SpiMosi             (mosi),
    .o_SpiMiso             (miso),
    .i_SampleReady         (sample_ready),
    .o_RegisterWriteEnable (we),
    .o_RegisterWriteNumber (num),
    .o_RegisterWriteValue  (val),
    .o_Overflow            (ovf),
    .o_Busy                (busy)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_strobes = 0;
  logic [23:0] pend[$];
  logic        exp_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: a completed frame is stored unless the buffer is full with no same-cycle pop.
  function automatic void model_frame(input logic [23:0] f, input bit sim_pop);
    if (pend.size() >= Depth && !sim_pop) exp_ovf = 1'b1;
    else pend.push_back(f);
  endfunction

  function automatic logic [7:0] exp_status();
    logic [4:0] c;
    c = (pend.size() > 31) ? 5'd31 : 5'(pend.size());
    return {exp_ovf, 2'b00, c};
  endfunction

  always @(negedge clk) begin
    if (rst_n && we) begin
      n_strobes++;
      if (pend.size() == 0) begin
        check("spurious_write", {31'b0, we}, 32'd0);
      end else begin
        logic [23:0] e;
        e = pend.pop_front();
        check("write_data", {8'h00, num, val}, {8'h00, e});
      end
    end
  end

  task automatic cs_begin();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (2 * Half) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (Half) @(negedge clk);
    cs_n = 1'b1;
    repeat (2 * Half) @(negedge clk);
  endtask

  task automatic sclk_low();
    repeat (Half) @(negedge clk);
    sclk = 1'b0;
  endtask

  // Shifts nbits of data MSB first; returns the first 8 MISO bits seen at rising SCLK.
  task automatic spi_bits(input logic [23:0] data, input int nbits, input bit ready_pulse,
                          input bit stop_at_last_rise, output logic [7:0] mb);
    mb = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = data[23-i];
      repeat (Half) @(negedge clk);
      if (i < 8) mb[7-i] = miso;
      sclk = 1'b1;
      if (stop_at_last_rise && i == nbits - 1) return;
      if (ready_pulse && i == nbits - 1) begin
        // Lands i_SampleReady in the same cycle the completed frame is pushed.
        repeat (Sync) @(negedge clk);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        repeat (Half - Sync - 1) @(negedge clk);
      end else begin
        repeat (Half) @(negedge clk);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int guard = 0;
`ifdef SAMPLE_ALIGNED_WRITES_EN
    if (pend.size() != 0) pulse_ready();
`endif
    while (pend.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check(tag, pend.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_we"}, {31'b0, we}, 32'd0);
    check({tag, "_num"}, {16'b0, num}, 32'd0);
    check({tag, "_val"}, {24'b0, val}, 32'd0);
    check({tag, "_ovf"}, {31'b0, ovf}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_miso"}, {31'b0, miso}, 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    sample_ready = 1'b0;
    pend.delete();
    exp_ovf = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  mb, st;
    logic [23:0] d;
    int          s0;

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

`ifndef SAMPLE_ALIGNED_WRITES_EN
    // Single frame: strobe exactly Sync+2 clocks after the 24th SCLK rise.
    cs_begin();
    st = exp_status();
    model_frame(24'hC0053A, 1'b0);
    spi_bits(24'hC0053A, 24, 1'b0, 1'b1, mb);
    check("t1_status", {24'b0, mb}, {24'b0, st});
    for (int k = 1; k <= int'(Sync) + 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("t1_we_clk%0d", k), {31'b0, we}, (k == int'(Sync) + 2) ? 32'd1 : 32'd0);
      if (k == int'(Sync) + 2) begin
        check("t1_num", {16'b0, num}, 32'h0000_C005);
        check("t1_val", {24'b0, val}, 32'h0000_003A);
      end
    end
    sclk_low();
    cs_end();
    wait_drain("t1_drain");
`endif

    // Partial frame of 13 bits discarded, then a full frame.
    s0 = n_strobes;
    cs_begin();
    spi_bits(24'hFFFFFF, 13, 1'b0, 1'b0, mb);
    cs_end();
    cs_begin();
    model_frame(24'h800001, 1'b0);
    spi_bits(24'h800001, 24, 1'b0, 1'b0, mb);
    cs_end();
    wait_drain("t3_drain");
    check("t3_write_count", n_strobes - s0, 1);

`ifdef SAMPLE_ALIGNED_WRITES_EN
    // Three queued frames wait for a sample pulse, then issue on consecutive cycles.
    s0 = n_strobes;
    cs_begin();
    for (int f = 0; f < 3; f++) begin
      d = 24'h100000 + 24'(f * 24'h010101);
      model_frame(d, 1'b0);
      spi_bits(d, 24, 1'b0, 1'b0, mb);
    end
    cs_end();
    repeat (20) @(negedge clk);
    check("t4_held", n_strobes - s0, 0);
    @(negedge clk);
    sample_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("t4_we_clk%0d", k), {31'b0, we}, (k < 3) ? 32'd1 : 32'd0);
      @(negedge clk);
      sample_ready = 1'b0;
    end
    wait_drain("t4_drain");

    // Nine frames with no pops: eight stored, ninth dropped, status then reads 0x88.
    for (int f = 0; f < 9; f++) begin
      cs_begin();
      st = exp_status();
      d = $urandom();
      model_frame(d, 1'b0);
      spi_bits(d, 24, 1'b0, 1'b0, mb);
      check($sformatf("t2_status%0d", f), {24'b0, mb}, {24'b0, st});
      cs_end();
    end
    check("t2_ovf", {31'b0, ovf}, {31'b0, exp_ovf});
    cs_begin();
    d = $urandom();
    model_frame(d, 1'b0);
    spi_bits(d, 24, 1'b0, 1'b0, mb);
    check("t2_status_after_drop", {24'b0, mb}, 32'h0000_0088);
    cs_end();
    wait_drain("t2_drain");
    check("t2_ovf_sticky", {31'b0, ovf}, 32'd1);
`endif

    // Reset in the middle of a frame.
    s0 = n_strobes;
    cs_begin();
    spi_bits(24'hABCDEF, 10, 1'b0, 1'b0, mb);
    check("t5_busy_midframe", {31'b0, busy}, 32'd1);
    #2;
    apply_reset();
    #1;
    check_outputs_zero("t5_frame_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t5_no_write_frame", n_strobes - s0, 0);

    // Reset in the middle of a drain.
`ifdef SAMPLE_ALIGNED_WRITES_EN
    cs_begin();
    for (int f = 0; f < 3; f++) begin
      d = $urandom();
      model_frame(d, 1'b0);
      spi_bits(d, 24, 1'b0, 1'b0, mb);
    end
    cs_end();
    s0 = n_strobes;
    @(negedge clk);
    sample_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t5_drain_started", {31'b0, we}, 32'd1);
    #1;
`else
    cs_begin();
    d = $urandom();
    model_frame(d, 1'b0);
    spi_bits(d, 24, 1'b0, 1'b1, mb);
    s0 = n_strobes;
    repeat (Sync + 1) @(posedge clk);
    #1;
    check("t5_pending_busy", {31'b0, busy}, 32'd1);
    check("t5_pending_we", {31'b0, we}, 32'd0);
    #1;
`endif
    apply_reset();
    #1;
    check_outputs_zero("t5_drain_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t5_no_write_drain", n_strobes - s0, 0);
    cs_begin();
    model_frame(24'h5A1234, 1'b0);
    spi_bits(24'h5A1234, 24, 1'b0, 1'b0, mb);
    check("t5_status_after_rst", {24'b0, mb}, 32'd0);
    cs_end();
    wait_drain("t5_drain");

`ifdef SAMPLE_ALIGNED_WRITES_EN
    // Push into a full FIFO in the same cycle as a pop: accepted, no overflow, order kept.
    s0 = n_strobes;
    for (int f = 0; f < 8; f++) begin
      cs_begin();
      d = $urandom();
      model_frame(d, 1'b0);
      spi_bits(d, 24, 1'b0, 1'b0, mb);
      cs_end();
    end
    cs_begin();
    st = exp_status();
    d = $urandom();
    model_frame(d, 1'b1);
    spi_bits(d, 24, 1'b1, 1'b0, mb);
    check("t6_status_full", {24'b0, mb}, {24'b0, st});
    cs_end();
    wait_drain("t6_drain");
    check("t6_ovf", {31'b0, ovf}, 32'd0);
    check("t6_write_count", n_strobes - s0, 9);
`endif

    // Random sessions: 1-3 frames per chip select, sometimes a trailing partial frame.
    for (int s = 0; s < 10; s++) begin
      int nfr;
      nfr = int'($urandom_range(1, 3));
      cs_begin();
      st = exp_status();
      for (int f = 0; f < nfr; f++) begin
        d = $urandom();
        model_frame(d, 1'b0);
        spi_bits(d, 24, 1'b0, 1'b0, mb);
        if (f == 0) check($sformatf("rand_status%0d", s), {24'b0, mb}, {24'b0, st});
      end
      if ($urandom_range(0, 3) == 0) spi_bits($urandom(), int'($urandom_range(1, 23)),
                                                1'b0, 1'b0, mb);
      cs_end();
      wait_drain($sformatf("rand_drain%0d", s));
    end
    check("final_ovf", {31'b0, ovf}, {31'b0, exp_ovf});
    check("final_idle", {31'b0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
